// File: rtl/ahblite_busmatrix_pkg.sv
// rtl/ahblite_busmatrix_pkg.sv - shared AHB-Lite bus matrix codes and round-robin helpers
package ahblite_busmatrix_pkg;

   typedef enum logic [1:0] {
      PORT_NONE = 2'b00,
      PORT_SYS  = 2'b01,
      PORT_DMA  = 2'b10,
      PORT_ACC  = 2'b11
   } port_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      SINGLE = 3'b000,
      INCR   = 3'b001,
      WRAP4  = 3'b010,
      INCR4  = 3'b011,
      WRAP8  = 3'b100,
      INCR8  = 3'b101,
      WRAP16 = 3'b110,
      INCR16 = 3'b111
   } hburst_e;

   // Port that follows p in the rotation 01 -> 10 -> 11 -> 01.
   function automatic logic [1:0] next_port(input logic [1:0] p);
      case (p)
         PORT_SYS: return PORT_DMA;
         PORT_DMA: return PORT_ACC;
         default:  return PORT_SYS;
      endcase
   endfunction

   // First requester found scanning from the port after last; req is {acc, dma, sys}.
   function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
      logic [1:0] cand;
      logic [1:0] pick;
      pick = PORT_NONE;
      cand = last;
      for (int i = 0; i < 3; i++) begin
         cand = next_port(cand);
         if ((pick == PORT_NONE) && req[cand - 2'd1]) pick = cand;
      end
      return pick;
   endfunction

   // SEQ beats that follow the NONSEQ of a fixed-length burst; undefined-length bursts are never held.
   function automatic logic [3:0] burst_seq_beats(input logic [2:0] hburst);
      case (hburst)
         WRAP4, INCR4:   return 4'd3;
         WRAP8, INCR8:   return 4'd7;
         WRAP16, INCR16: return 4'd15;
         default:        return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahblite_arb_burst_counter.sv
// rtl/ahblite_arb_burst_counter.sv - remaining-SEQ-beat counter for the DTCM arbiter
import ahblite_busmatrix_pkg::*;

module ahblite_arb_burst_counter (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic [1:0] htrans,
   input  logic [2:0] hburst,
   input  logic       hsel,
   input  logic       hready,
   input  logic       noport,
   output logic [3:0] beats,
   output logic       beats_nz
);

   // Count only completed owner transfers; SEQ at zero saturates, IDLE cuts the burst short.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         beats <= 4'd0;
      end else if (hready && hsel && !noport) begin
         case (htrans)
            NONSEQ:  beats <= burst_seq_beats(hburst);
            SEQ:     if (beats != 4'd0) beats <= beats - 4'd1;
            BUSY:    beats <= beats;
            default: beats <= 4'd0;
         endcase
      end
   end

   assign beats_nz = (beats != 4'd0);

endmodule

// File: rtl/ahblite_busmatrix_rr_arbiter_dtcm.sv
// rtl/ahblite_busmatrix_rr_arbiter_dtcm.sv - burst-aware round-robin DTCM port arbiter; ARB_LOCK_EN adds locked-transfer hold
import ahblite_busmatrix_pkg::*;

module ahblite_busmatrix_rr_arbiter_dtcm (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       REQ_SYS,
   input  logic       REQ_DMA,
   input  logic       REQ_ACC,
   input  logic       HREADY_Outputstage_DTCM,
   input  logic       HSEL_Outputstage_DTCM,
   input  logic [1:0] HTRANS_Outputstage_DTCM,
   input  logic [2:0] HBURST_Outputstage_DTCM,
`ifdef ARB_LOCK_EN
   input  logic       HMASTLOCK_Outputstage_DTCM,
`endif
   output logic [1:0] PORT_SEL_ARBITER_DTCM,
   output logic       PORT_NOSEL_ARBITER_DTCM,
   output logic       BURST_HOLD_ARBITER_DTCM
);

   logic [1:0] selport;
   logic       noport;
   logic [1:0] last;
   logic [1:0] pick;
   logic       noport_next;
   logic [3:0] beats;
   logic       beats_nz;
   logic       locked;
   logic       hold;

   assign pick        = rr_pick(last, {REQ_ACC, REQ_DMA, REQ_SYS});
   assign noport_next = ~REQ_SYS & ~REQ_DMA & ~REQ_ACC & ~HSEL_Outputstage_DTCM;
   assign hold        = beats_nz | locked;

   ahblite_arb_burst_counter u_burst_counter (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .htrans   (HTRANS_Outputstage_DTCM),
      .hburst   (HBURST_Outputstage_DTCM),
      .hsel     (HSEL_Outputstage_DTCM),
      .hready   (HREADY_Outputstage_DTCM),
      .noport   (noport),
      .beats    (beats),
      .beats_nz (beats_nz)
   );

   // Re-arbitrate on each completed transfer unless a burst or lock freezes the grant.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         selport <= PORT_NONE;
         noport  <= 1'b1;
         last    <= PORT_ACC;
      end else if (HREADY_Outputstage_DTCM && !hold) begin
         selport <= pick;
         noport  <= noport_next;
         if (pick != PORT_NONE) last <= pick;
      end
   end

`ifdef ARB_LOCK_EN
   // Track the owner's lock: set/cleared by active transfers, released by an unlocked IDLE.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         locked <= 1'b0;
      end else if (HREADY_Outputstage_DTCM) begin
         if (HSEL_Outputstage_DTCM &&
             ((HTRANS_Outputstage_DTCM == NONSEQ) || (HTRANS_Outputstage_DTCM == SEQ)))
            locked <= HMASTLOCK_Outputstage_DTCM;
         else if ((HTRANS_Outputstage_DTCM == IDLE) && !HMASTLOCK_Outputstage_DTCM)
            locked <= 1'b0;
      end
   end
`else
   assign locked = 1'b0;
`endif

   assign PORT_SEL_ARBITER_DTCM   = selport;
   assign PORT_NOSEL_ARBITER_DTCM = noport;
   assign BURST_HOLD_ARBITER_DTCM = (beats != 4'd0) | locked;

endmodule

// File: tb/tb_ahblite_busmatrix_rr_arbiter_dtcm.sv
// tb/tb_ahblite_busmatrix_rr_arbiter_dtcm.sv - scoreboard bench for the DTCM round-robin arbiter
module tb_ahblite_busmatrix_rr_arbiter_dtcm;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
   localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011, B_INCR8 = 3'b101;
   localparam logic [2:0] B_WRAP16 = 3'b110, B_INCR16 = 3'b111;

   logic       HCLK = 1'b0;
   logic       HRESETn;
   logic       req_sys, req_dma, req_acc;
   logic       hready, hsel;
   logic [1:0] htrans;
   logic [2:0] hburst;
   logic       hmastlock;
   logic [1:0] PORT_SEL;
   logic       PORT_NOSEL, BURST_HOLD;

   int checks = 0;
   int errors = 0;

   // expected {PORT_SEL, PORT_NOSEL, BURST_HOLD}
   logic [3:0] exp_q[$];

   typedef struct {
      logic [2:0] req;
      logic       rdy;
      logic       sel;
      logic [1:0] tr;
      logic [2:0] bu;
      logic       lk;
      logic [3:0] exp;
   } row_t;

   ahblite_busmatrix_rr_arbiter_dtcm dut (
      .HCLK                       (HCLK),
      .HRESETn                    (HRESETn),
      .REQ_SYS                    (req_sys),
      .REQ_DMA                    (req_dma),
      .REQ_ACC                    (req_acc),
      .HREADY_Outputstage_DTCM    (hready),
      .HSEL_Outputstage_DTCM      (hsel),
      .HTRANS_Outputstage_DTCM    (htrans),
      .HBURST_Outputstage_DTCM    (hburst),
`ifdef ARB_LOCK_EN
      .HMASTLOCK_Outputstage_DTCM (hmastlock),
`endif
      .PORT_SEL_ARBITER_DTCM      (PORT_SEL),
      .PORT_NOSEL_ARBITER_DTCM    (PORT_NOSEL),
      .BURST_HOLD_ARBITER_DTCM    (BURST_HOLD)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached got running want finished");
      $fatal(1, "watchdog");
   end

   function automatic row_t mk(input logic [2:0] req, input logic rdy, input logic sel,
                               input logic [1:0] tr, input logic [2:0] bu, input logic lk,
                               input logic [3:0] exp);
      row_t r;
      r.req = req; r.rdy = rdy; r.sel = sel; r.tr = tr; r.bu = bu; r.lk = lk; r.exp = exp;
      return r;
   endfunction

   task automatic drive(input row_t r);
      {req_acc, req_dma, req_sys} = r.req;
      hready    = r.rdy;
      hsel      = r.sel;
      htrans    = r.tr;
      hburst    = r.bu;
      hmastlock = r.lk;
      exp_q.push_back(r.exp);
   endtask

   task automatic idle_inputs();
      {req_acc, req_dma, req_sys} = 3'b000;
      hready = 1'b1; hsel = 1'b0; htrans = T_IDLE; hburst = B_SINGLE; hmastlock = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      HRESETn = 1'b0;
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
   endtask

   task automatic test_reset();
      logic [3:0] got, want;
      idle_inputs();
      HRESETn = 1'b0;
      exp_q.push_back(4'b0010);
      repeat (2) @(posedge HCLK);
      #1;
      got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL reset sel/nosel/hold got %b want %b", got, want);
      end
      HRESETn = 1'b1;
   endtask

   task automatic test_round_robin();
      row_t rows[$];
      logic [3:0] got, want;
      do_reset();
      rows.push_back(mk(3'b111, 1, 1, T_NSEQ, B_SINGLE, 0, 4'b0100));
      rows.push_back(mk(3'b111, 1, 1, T_NSEQ, B_SINGLE, 0, 4'b1000));
      rows.push_back(mk(3'b111, 1, 1, T_NSEQ, B_SINGLE, 0, 4'b1100));
      rows.push_back(mk(3'b111, 1, 1, T_NSEQ, B_SINGLE, 0, 4'b0100));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(posedge HCLK); #1;
         got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL round_robin step %0d got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_incr4_hold();
      row_t rows[$];
      logic [3:0] got, want;
      do_reset();
      rows.push_back(mk(3'b010, 1, 0, T_IDLE, B_SINGLE, 0, 4'b1000));
      rows.push_back(mk(3'b010, 1, 1, T_NSEQ, B_INCR4,  0, 4'b1001));
      rows.push_back(mk(3'b011, 1, 1, T_SEQ,  B_INCR4,  0, 4'b1001));
      rows.push_back(mk(3'b011, 1, 1, T_SEQ,  B_INCR4,  0, 4'b1001));
      rows.push_back(mk(3'b011, 1, 1, T_SEQ,  B_INCR4,  0, 4'b1000));
      rows.push_back(mk(3'b001, 1, 0, T_IDLE, B_SINGLE, 0, 4'b0100));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(posedge HCLK); #1;
         got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL incr4_hold step %0d got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_incr8_stall_busy();
      row_t rows[$];
      logic [3:0] got, want;
      do_reset();
      rows.push_back(mk(3'b001, 1, 0, T_IDLE, B_SINGLE, 0, 4'b0100));
      rows.push_back(mk(3'b001, 1, 1, T_NSEQ, B_INCR8,  0, 4'b0101));
      rows.push_back(mk(3'b011, 1, 1, T_SEQ,  B_INCR8,  0, 4'b0101));
      for (int k = 0; k < 5; k++) rows.push_back(mk(3'b011, 0, 1, T_SEQ, B_INCR8, 0, 4'b0101));
      rows.push_back(mk(3'b011, 1, 1, T_BUSY, B_INCR8, 0, 4'b0101));
      for (int k = 0; k < 5; k++) rows.push_back(mk(3'b011, 1, 1, T_SEQ, B_INCR8, 0, 4'b0101));
      rows.push_back(mk(3'b011, 1, 1, T_SEQ,  B_INCR8,  0, 4'b0100));
      rows.push_back(mk(3'b010, 1, 0, T_IDLE, B_SINGLE, 0, 4'b1000));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(posedge HCLK); #1;
         got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL incr8_stall_busy step %0d got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_wrap16_early_idle();
      row_t rows[$];
      logic [3:0] got, want;
      do_reset();
      rows.push_back(mk(3'b100, 1, 0, T_IDLE, B_SINGLE, 0, 4'b1100));
      rows.push_back(mk(3'b100, 1, 1, T_NSEQ, B_WRAP16, 0, 4'b1101));
      for (int k = 0; k < 6; k++) rows.push_back(mk(3'b101, 1, 1, T_SEQ, B_WRAP16, 0, 4'b1101));
      rows.push_back(mk(3'b001, 1, 1, T_IDLE, B_WRAP16, 0, 4'b1100));
      rows.push_back(mk(3'b001, 1, 0, T_IDLE, B_SINGLE, 0, 4'b0100));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(posedge HCLK); #1;
         got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL wrap16_early_idle step %0d got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_noport();
      row_t rows[$];
      logic [3:0] got, want;
      do_reset();
      rows.push_back(mk(3'b001, 1, 0, T_IDLE, B_SINGLE, 0, 4'b0100));
      rows.push_back(mk(3'b000, 1, 0, T_IDLE, B_SINGLE, 0, 4'b0010));
      rows.push_back(mk(3'b000, 1, 1, T_IDLE, B_SINGLE, 0, 4'b0000));
      rows.push_back(mk(3'b000, 1, 0, T_IDLE, B_SINGLE, 0, 4'b0010));
      rows.push_back(mk(3'b111, 1, 0, T_IDLE, B_SINGLE, 0, 4'b1000));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(posedge HCLK); #1;
         got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL noport step %0d got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      row_t rows[$];
      logic [3:0] got, want;
      do_reset();
      rows.push_back(mk(3'b001, 1, 0, T_IDLE, B_SINGLE, 0, 4'b0100));
      rows.push_back(mk(3'b001, 1, 1, T_NSEQ, B_INCR16, 0, 4'b0101));
      rows.push_back(mk(3'b001, 1, 1, T_SEQ,  B_INCR16, 0, 4'b0101));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(posedge HCLK); #1;
         got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset_mid_burst step %0d got %b want %b", i, got, want);
         end
      end
      #2 HRESETn = 1'b0;
      exp_q.push_back(4'b0010);
      #1;
      got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL reset_mid_burst async got %b want %b", got, want);
      end
      @(posedge HCLK); #1 HRESETn = 1'b1;
      drive(mk(3'b111, 1, 0, T_IDLE, B_SINGLE, 0, 4'b0100));
      @(posedge HCLK); #1;
      got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL reset_mid_burst first_grant got %b want %b", got, want);
      end
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      row_t rows[$];
      logic [3:0] got, want;
      do_reset();
      rows.push_back(mk(3'b001, 1, 0, T_IDLE, B_SINGLE, 0, 4'b0100));
      rows.push_back(mk(3'b001, 1, 1, T_NSEQ, B_SINGLE, 1, 4'b0101));
      rows.push_back(mk(3'b011, 1, 1, T_NSEQ, B_SINGLE, 1, 4'b0101));
      rows.push_back(mk(3'b011, 1, 1, T_NSEQ, B_SINGLE, 1, 4'b0101));
      rows.push_back(mk(3'b011, 1, 1, T_IDLE, B_SINGLE, 0, 4'b0100));
      rows.push_back(mk(3'b010, 1, 0, T_IDLE, B_SINGLE, 0, 4'b1000));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(posedge HCLK); #1;
         got = {PORT_SEL, PORT_NOSEL, BURST_HOLD};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL lock step %0d got %b want %b", i, got, want);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_incr4_hold();
      test_incr8_stall_busy();
      test_wrap16_early_idle();
      test_noport();
      test_reset_mid_burst();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahblite_busmatrix_rr_arbiter_dtcm.md
# ahblite_busmatrix_rr_arbiter_dtcm

Round-robin, burst-aware slave-port arbiter for the DTCM output stage of the AHB-Lite bus matrix. It shares the DTCM port between the SYS, DMA and ACC input stages. Grant decisions rotate fairly among requesters. Once a fixed-length burst (INCR4/8/16, WRAP4/8/16) has started, the port stays with its owner until the burst completes. The block drives the output-stage multiplexer select with the same port encoding the matrix already uses: 01 SYS, 10 DMA, 11 ACC, 00 none.

## Interface
- No parameters.
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- REQ_SYS / REQ_DMA / REQ_ACC  in  1 each  access request from each input stage
- HREADY_Outputstage_DTCM  in  1  DTCM transfer-complete; the block arbitrates only on cycles where it is high
- HSEL_Outputstage_DTCM  in  1  DTCM selected by the current owner
- HTRANS_Outputstage_DTCM  in  2  owner's address-phase HTRANS
- HBURST_Outputstage_DTCM  in  3  owner's address-phase HBURST
- HMASTLOCK_Outputstage_DTCM  in  1  locked transfer (present only with ARB_LOCK_EN)
- PORT_SEL_ARBITER_DTCM  out  2  registered port select
- PORT_NOSEL_ARBITER_DTCM  out  1  registered "no port selected"
- BURST_HOLD_ARBITER_DTCM  out  1  registered; 1 while a grant is frozen by a burst or a lock

## Operation
- State:
  - selport[1:0]
  - noport
  - last[1:0], the last granted port
  - beats[3:0], the number of remaining SEQ beats
  - locked (only with ARB_LOCK_EN)
- hold = (beats≠0) | locked.
- Arbitration, on an HREADY-high cycle with hold=0:
  - Candidates are scanned in round-robin order, starting at the port after last: 01→10→11→01.
  - The first port with its REQ high wins.
  - If no REQ is high, the result is 00.
- noport_next = ~REQ_SYS & ~REQ_DMA & ~REQ_ACC & ~HSEL_Outputstage_DTCM.
- Register update, on an HREADY-high cycle:
  - hold=0: selport←arbitration result; noport←noport_next; last←result if the result ≠00, otherwise unchanged.
  - hold=1: selport, noport and last keep their values.
- Burst counter, on an HREADY-high cycle with HSEL=1 and noport=0:
  - HTRANS=NONSEQ with HBURST INCR4/WRAP4: beats←3.
  - HTRANS=NONSEQ with HBURST INCR8/WRAP8: beats←7.
  - HTRANS=NONSEQ with HBURST INCR16/WRAP16: beats←15.
  - HTRANS=NONSEQ with HBURST SINGLE or INCR: beats←0.
  - HTRANS=SEQ with beats>0: beats←beats−1.
  - HTRANS=BUSY: beats unchanged.
  - HTRANS=IDLE: beats←0, for early termination.
- Undefined-length INCR is never held; it is re-arbitrated on every beat.
- The counter never wraps: a SEQ arriving with beats=0 leaves it at 0.
- hold is evaluated from the pre-update state. As a result, the last SEQ beat (beats 1→0) completes under hold, and arbitration resumes on the next HREADY-high cycle.
- A NONSEQ presented while beats>0 reloads beats (the owner restarted its burst) and keeps the grant.
- HREADY low: every register holds its value.

## Timing
- Reset values:
  - PORT_SEL=00
  - PORT_NOSEL=1
  - BURST_HOLD=0
  - last=11, so SYS has first priority after reset
  - beats=0
  - locked=0
- A grant takes effect one HCLK after the HREADY-high sampling edge. There are no combinational paths from inputs to outputs.
- BURST_HOLD = registered (beats≠0 | locked) and updates on the same edge as beats.
- If a reset is asserted in the middle of a burst, every register returns to its reset value immediately, without waiting for a clock edge.
- When requests arrive at the same time, round-robin order decides the winner; no port has fixed priority.

## Configuration
- ARB_LOCK_EN defined:
  - The HMASTLOCK_Outputstage_DTCM port exists.
  - On an HREADY-high cycle with HSEL=1 and HTRANS NONSEQ/SEQ, locked←HMASTLOCK.
  - On an HREADY-high cycle with HTRANS=IDLE and HMASTLOCK=0, locked←0.
  - A locked owner keeps the port across SINGLE and INCR transfers.
- ARB_LOCK_EN undefined:
  - The port is absent.
  - locked is the constant 0.

## Structure
- Shared package ahblite_busmatrix_pkg holds:
  - port codes PORT_NONE/SYS/DMA/ACC
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ
  - HBURST codes
- The beat counter lives in a separate sub-module, ahblite_arb_burst_counter. It takes HTRANS, HBURST, HSEL and HREADY as inputs and outputs beats and beats_nz.

## Test plan
- Reset, then REQ_SYS=REQ_DMA=REQ_ACC=1 with HREADY=1 and HTRANS=NONSEQ SINGLE every cycle → PORT_SEL sequence 01,10,11,01 on consecutive cycles.
- DMA issues a NONSEQ INCR4 followed by 3 SEQ beats while SYS requests → PORT_SEL stays 10 for 4 cycles with BURST_HOLD=1 over the three SEQ-beat cycles, then 01.
- An INCR8 owner stalls with HREADY=0 for 5 cycles and inserts one BUSY → beats does not decrement during the stall or on the BUSY, and the grant is held until the 7th SEQ completes.
- ACC owns the port in a WRAP16 and issues IDLE at beats=9 → beats=0, and the next HREADY-high cycle arbitrates to a waiting SYS.
- All REQ low with HSEL=0 → PORT_NOSEL=1 and PORT_SEL=00. Asserting HRESETn low in the middle of a burst → outputs return to reset values immediately.
- With ARB_LOCK_EN: SYS issues locked SINGLE transfers (HMASTLOCK=1) while DMA requests → PORT_SEL stays 01 until SYS issues an IDLE with HMASTLOCK=0, then 10.
